junction_dose_sequencer: RTL and testbench
==========================================

# junction_dose_sequencer

Timed valve sequencer for an N-inlet mixing junction. It admits one inlet channel at a time into a shared diffusion mixer, each for a programmable dwell, and inserts a fixed all-closed settle gap between doses (break-before-make). It repeats the full channel sweep for a programmed number of rounds. It sits between the host control registers and the pneumatic valve drivers of a multi-inlet junction.

## Interface
Parameters:
- N_CH, 4, number of inlet channels (2..16)
- CNT_W, 16, width of dwell registers and dwell counter
- SETTLE_CYC, 2, all-closed gap after every dose, in cycles (≥1)
- CH_W, $clog2(N_CH), channel index width (derived)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write dwell register wr_ch; ignored while busy
- wr_ch  in  CH_W  channel index to program
- wr_dwell  in  CNT_W  dose length in cycles; 0 = channel skipped
- start  in  1  begin sequence; sampled only in IDLE
- n_rounds  in  8  sweep count, sampled on accepted start
- abort  in  1  terminate any sequence
- valve_open  out  N_CH  inlet valve enables, one-hot or zero
- busy  out  1  high in DOSE and GAP
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort of an active sequence
- cur_ch  out  CH_W  channel currently dosing (last dosed during GAP)
- round_cnt  out  8  completed rounds in current sequence

## Operation
- States: IDLE, DOSE, GAP, DONE.
- Dwell registers: N_CH × CNT_W. Cleared to 0 on reset. Written on wr_en in IDLE or DONE only.
- Next-channel search is combinational priority. It selects the lowest-index channel above the current one with a nonzero dwell. If none exists, the round ends.
- IDLE + start:
  - n_rounds=0 or all dwell=0 → DONE.
  - Otherwise → DOSE on the lowest nonzero channel. Load the dwell counter; round_cnt=0.
- DOSE:
  - valve_open = one-hot(cur_ch) for exactly dwell[cur_ch] cycles.
  - Then → GAP, counter loaded with SETTLE_CYC.
- GAP:
  - valve_open=0 for SETTLE_CYC cycles.
  - Then → DOSE on the next channel, if one exists.
  - Else round_cnt+1. If round_cnt+1 == n_rounds_latched → DONE. Otherwise → DOSE on the lowest nonzero channel (wrap).
- DONE: done=1, busy=0 for one cycle, then → IDLE. round_cnt holds until the next accepted start.
- Dwell values are latched per dose at DOSE entry. Writes are blocked while busy, so a sequence always uses a consistent table.
- abort has priority over every other transition:
  - From DOSE or GAP → IDLE on the next edge; valve_open=0, aborted=1 for one cycle, done not pulsed.
  - In IDLE or DONE: no effect; a DONE pulse still completes.
- start while busy: ignored.
- Simultaneous start and abort in IDLE: abort wins, no sequence starts.
- Simultaneous wr_en and start in IDLE: the write takes effect first, and the channel search sees the new value.
- Reset (asynchronous, any state): state=IDLE, all outputs 0, dwell registers 0, counters 0. Valves close immediately on rst_n falling, without waiting for a clock.

## Timing
- Registered outputs; all driven from state and counter registers.
- Start latency: start sampled at edge k → valve_open active from cycle k+1.
- One round length: Σ dwell(nonzero) + SETTLE_CYC × (number of nonzero channels).
- done pulses in the cycle after the final GAP cycle.
- Never two valves open in the same cycle. There are always ≥SETTLE_CYC closed cycles between different, or repeated, openings.
- Dwell counter counts dwell..1. Maximum dwell = 2^CNT_W−1; no wrap.

## Test plan
- Setup for the first two tests: N_CH=4, SETTLE_CYC=2; dwell = {ch0:3, ch1:0, ch2:2, ch3:1}; n_rounds=2; start at cycle 0. Expected per round:
  - ch0 open 3 cycles, gap 2
  - ch2 open 2 cycles, gap 2 (ch1 skipped)
  - ch3 open 1 cycle, gap 2
- Schedule: round 1 occupies cycles 1–12, round 2 cycles 13–24. done pulses at cycle 25 with round_cnt=2, busy low at 25.
- Abort: same table, abort asserted at cycle 7 (ch2 dosing) → valve_open=0 and aborted=1 at cycle 8, state IDLE, done never pulses.
- Degenerate start: all dwell=0 with start → done at cycle 1 and valve_open stays 0. Separately, n_rounds=0 → same result.
- Write protection: wr_en ch0=9 while busy → ignored, ch0 still doses 3 cycles. The same write issued in IDLE before start → ch0 doses 9 cycles.
- Reset mid-DOSE: rst_n low asynchronously during a ch2 dose → valve_open=0 before the next edge. After release, all dwell read as 0 (start gives an immediate done), busy=0.

Source files
------------

// File: rtl/junction_dose_sequencer.sv
// Timed valve sequencer: doses one inlet at a time for its programmed dwell,
// separated by fixed all-closed settle gaps, for a programmed number of sweeps.
module junction_dose_sequencer #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2,
  parameter int CH_W       = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_dwell,
  input  logic             start,
  input  logic [7:0]       n_rounds,
  input  logic             abort,
  output logic [N_CH-1:0]  valve_open,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CH_W-1:0]  cur_ch,
  output logic [7:0]       round_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DOSE, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       round_cnt_q, round_cnt_d;
  logic [7:0]       n_rounds_q, n_rounds_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] dwell_q   [N_CH];
  logic [CNT_W-1:0] dwell_eff [N_CH];

  logic             wr_ok;
  logic             first_found, next_found;
  logic [CH_W-1:0]  first_ch, next_ch;

  assign wr_ok = wr_en && (state_q == S_IDLE || state_q == S_DONE);

  // Same-cycle writes are folded in so a start alongside a write sees the new table.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      dwell_eff[i] = dwell_q[i];
      if (wr_ok && wr_ch == CH_W'(i)) dwell_eff[i] = wr_dwell;
    end
  end

  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!first_found && dwell_eff[i] != '0) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (!next_found && CH_W'(i) > cur_ch_q && dwell_eff[i] != '0) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    cnt_d       = cnt_q;
    round_cnt_d = round_cnt_q;
    n_rounds_d  = n_rounds_q;
    aborted_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          n_rounds_d  = n_rounds;
          round_cnt_d = '0;
          if (n_rounds == '0 || !first_found) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_DOSE;
            cur_ch_d = first_ch;
            cnt_d    = dwell_eff[first_ch];
          end
        end
      end
      S_DOSE: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(SETTLE_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          if (next_found) begin
            state_d  = S_DOSE;
            cur_ch_d = next_ch;
            cnt_d    = dwell_eff[next_ch];
          end else begin
            round_cnt_d = round_cnt_q + 8'd1;
            if (({1'b0, round_cnt_q} + 9'd1) == {1'b0, n_rounds_q}) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_DOSE;
              cur_ch_d = first_ch;
              cnt_d    = dwell_eff[first_ch];
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_ch_q    <= '0;
      cnt_q       <= '0;
      round_cnt_q <= '0;
      n_rounds_q  <= '0;
      aborted_q   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) dwell_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      cnt_q       <= cnt_d;
      round_cnt_q <= round_cnt_d;
      n_rounds_q  <= n_rounds_d;
      aborted_q   <= aborted_d;
      for (int unsigned i = 0; i < N_CH; i++) dwell_q[i] <= dwell_eff[i];
    end
  end

  always_comb begin
    valve_open = '0;
    if (state_q == S_DOSE) valve_open[cur_ch_q] = 1'b1;
  end

  assign busy      = (state_q == S_DOSE) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign aborted   = aborted_q;
  assign cur_ch    = cur_ch_q;
  assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_junction_dose_sequencer.sv
// Self-checking bench: a per-cycle expected schedule is built from the dwell
// table and round count, then compared against the sequencer outputs.
module tb_junction_dose_sequencer;

  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int ST  = 2;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [CW-1:0]  wr_dwell = '0;
  logic           start = 1'b0;
  logic [7:0]     n_rounds = '0;
  logic           abort = 1'b0;
  logic [N-1:0]   valve_open;
  logic           busy, done, aborted;
  logic [CHW-1:0] cur_ch;
  logic [7:0]     round_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0]   v;
    logic           busy;
    logic           done;
    logic [CHW-1:0] ch;
    logic [7:0]     rc;
  } exp_t;

  int unsigned model_dw [N];
  exp_t        exp_q [$];
  bit          degen;

  junction_dose_sequencer #(.N_CH(N), .CNT_W(CW), .SETTLE_CYC(ST)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_dwell(wr_dwell),
    .start(start), .n_rounds(n_rounds), .abort(abort), .valve_open(valve_open),
    .busy(busy), .done(done), .aborted(aborted), .cur_ch(cur_ch), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_all();
    for (int c = 0; c < N; c++) begin
      wr_en = 1'b1;
      wr_ch = CHW'(c);
      wr_dwell = CW'(model_dw[c]);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Expected per-cycle schedule starting at the cycle after start is sampled.
  function automatic void build(input int unsigned nr);
    int unsigned last;
    bit any;
    exp_t e;
    last = 0;
    any = 0;
    exp_q.delete();
    for (int c = 0; c < N; c++) if (model_dw[c] != 0) any = 1;
    degen = (nr == 0) || !any;
    if (!degen) begin
      for (int unsigned r = 0; r < nr; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          if (model_dw[c] != 0) begin
            e = '0;
            e.busy = 1'b1;
            e.ch = CHW'(c);
            e.rc = 8'(r);
            e.v[c] = 1'b1;
            for (int unsigned k = 0; k < model_dw[c]; k++) exp_q.push_back(e);
            e.v = '0;
            for (int k = 0; k < ST; k++) exp_q.push_back(e);
            last = c;
          end
        end
      end
    end
    e = '0;
    e.done = 1'b1;
    e.ch = CHW'(last);
    e.rc = 8'(nr);
    exp_q.push_back(e);
  endfunction

  task automatic run_seq(input int nr, input int abort_at, input int busy_wr_at,
                         input int rst_at, input bit rnd_start, input int co_ch, input int co_val);
    if (co_ch >= 0) begin
      model_dw[co_ch] = co_val;
      wr_en = 1'b1;
      wr_ch = CHW'(co_ch);
      wr_dwell = CW'(co_val);
    end
    build(nr);
    n_rounds = 8'(nr);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int t = 1; t <= exp_q.size(); t++) begin
      exp_t e = exp_q[t-1];
      if (abort_at > 0 && t == abort_at + 1) begin
        start = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_valve", valve_open, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("post_abort_pulse", aborted, 0);
        chk("post_abort_done", done, 0);
        chk("post_abort_busy", busy, 0);
        return;
      end
      chk("valve", valve_open, e.v);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("aborted_idle", aborted, 0);
      if (e.busy) begin
        chk("cur_ch", cur_ch, e.ch);
        chk("round_cnt", round_cnt, e.rc);
      end
      if (e.done && !degen) chk("final_round_cnt", round_cnt, e.rc);
      if (rst_at > 0 && t == rst_at) begin
        start = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valve_async", valve_open, 0);
        chk("rst_busy_async", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      start = (rnd_start && e.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (t == abort_at);
      wr_en = (t == busy_wr_at);
      wr_ch = '0;
      wr_dwell = CW'(9);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    wr_en = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valve", valve_open, 0);
  endtask

  initial begin
    int busylen;
    int ab;
    int nr;

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_valve", valve_open, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_aborted", aborted, 0);
    chk("reset_cur_ch", cur_ch, 0);
    chk("reset_round_cnt", round_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Reference table: two rounds, done at cycle 25.
    model_dw = '{3, 0, 2, 1};
    program_all();
    run_seq(2, 0, 0, 0, 0, -1, 0);

    // Abort while ch2 doses.
    run_seq(2, 7, 0, 0, 1, -1, 0);

    // Write while busy must not alter the table.
    run_seq(2, 0, 3, 0, 0, -1, 0);

    // Same write in IDLE takes effect.
    model_dw[0] = 9;
    program_all();
    run_seq(1, 0, 0, 0, 0, -1, 0);

    // Zero rounds completes immediately.
    run_seq(0, 0, 0, 0, 0, -1, 0);

    // All-zero table completes immediately.
    model_dw = '{0, 0, 0, 0};
    program_all();
    run_seq(1, 0, 0, 0, 0, -1, 0);

    // Write coincident with start is visible to the channel search.
    run_seq(1, 0, 0, 0, 0, 2, 4);

    // Start and abort together in IDLE: nothing starts, no pulse.
    start = 1'b1;
    abort = 1'b1;
    n_rounds = 8'd1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done", done, 0);
    chk("start_abort_pulse", aborted, 0);
    tick();
    chk("start_abort_busy2", busy, 0);
    chk("start_abort_done2", done, 0);

    // Randomized tables, round counts, aborts and spurious starts.
    for (int it = 0; it < 14; it++) begin
      for (int c = 0; c < N; c++)
        model_dw[c] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
      nr = $urandom_range(0, 3);
      program_all();
      build(nr);
      busylen = exp_q.size() - 1;
      ab = (busylen > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, busylen) : 0;
      run_seq(nr, ab, 0, 0, 1, -1, 0);
    end

    // Asynchronous reset during the ch2 dose, then the table must read back empty.
    model_dw = '{3, 0, 2, 1};
    program_all();
    run_seq(2, 0, 0, 7, 0, -1, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valve", valve_open, 0);
    model_dw = '{0, 0, 0, 0};
    run_seq(1, 0, 0, 0, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
